// File: rtl/tx_stream_pkg.sv
// Shared types and defaults for the result-word transmit stream.
package tx_stream_pkg;

    localparam int unsigned DefaultWidth     = 16;
    localparam int unsigned DefaultGapCycles = 2;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; writes while full and reads while empty are ignored.
module sync_fifo
    import tx_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign rd_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; clearing the pointers is enough to discard it.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues result words and launches them one at a time into uart_tx with an idle gap between frames.
module uart_tx_feeder
    import tx_stream_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned GAP_CYCLES = DefaultGapCycles
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [WIDTH-1:0]           tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       idle
);

    localparam logic [7:0] GapInit = 8'(GAP_CYCLES);

    tx_state_e        state_q, state_d;
    logic [7:0]       gap_q, gap_d;
    logic             tx_start_q, tx_start_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             overflow_q, overflow_d;
    logic             pop;
    logic [WIDTH-1:0] head;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // A drop is judged against the registered full flag, regardless of a same-cycle pop.
    assign overflow_d = overflow_q | (wr_en & full);

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (!empty) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = head;
                    state_d    = StLaunch;
                end
            end
            StLaunch: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                    gap_d   = GapInit;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gap_q      <= GapInit;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign idle     = empty & (state_q == StIdle) & ~tx_busy;

endmodule
